// File: rtl/mem_arbiter_pkg.sv
// Shared types for the main-memory arbiter.
//   arb_state_e : arbiter FSM states
//   owner_e     : which cache currently owns (or last owned) the memory port
//   d_wins()    : IDLE arbitration decision, alternating on ties
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GNT_I = 2'd1,
        ARB_GNT_D = 2'd2,
        ARB_DRAIN = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_e;

    // On a tie the side that did not win last time gets the port.
    function automatic logic d_wins(input logic i_req, input logic d_req, input owner_e last);
        return d_req && (!i_req || last == OWNER_I);
    endfunction

endpackage

// File: rtl/mem_outstanding_ctr.sv
// Outstanding-read counter for the memory arbiter.
//   clk, rst  : clock, synchronous active-high reset
//   inc       : a granted read was issued this cycle
//   dec       : a read word returned this cycle
//   zero_nxt  : counter will be zero after this cycle's update
//   ovf       : this increment would take the count past LIMIT
//   unf       : a word returned with nothing outstanding
module mem_outstanding_ctr #(
    parameter int OUT_W = 3,
    parameter int LIMIT = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic zero_nxt,
    output logic ovf,
    output logic unf
);

    localparam logic [OUT_W-1:0] LIM = OUT_W'(LIMIT);

    logic [OUT_W-1:0] cnt;
    logic [OUT_W-1:0] cnt_nxt;

    // Saturating at both ends: an underflow leaves the count at zero and
    // an overflow never wraps back to a small value.
    always_comb begin
        cnt_nxt = cnt;
        if (inc && !dec && cnt != '1)
            cnt_nxt = cnt + 1'b1;
        else if (dec && !inc && cnt != '0)
            cnt_nxt = cnt - 1'b1;
    end

    assign zero_nxt = (cnt_nxt == '0);
    assign ovf      = inc && !dec && (cnt >= LIM);
    // A return with an empty counter is a protocol error even when a new
    // read issues in the same cycle; the memory cannot answer that fast.
    assign unf      = dec && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else
            cnt <= cnt_nxt;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter for the single multicycle main-memory port shared by the I-cache
// fill FSM and the D-cache fill / write-through path. One owner at a time,
// held for the whole burst including returning data.
//   clk, rst                      : clock, synchronous active-high reset
//   i_busy, i_read_req, i_mem_addr: I-cache fill request, read strobe, address
//   d_busy, d_read_req, d_wrt_mem : D-cache fill request, read strobe, write strobe
//   d_mem_addr, d_wdata           : D-cache address and write data
//   mem_rdata, mem_valid          : memory read return
//   i_grant, d_grant              : current owner with issue rights
//   mem_addr/en/wr/wdata          : memory request port
//   i_data_valid, d_data_valid    : returning word routed to its owner
//   mem_data                      : read data pass-through to both caches
//   err                           : sticky protocol error (counter over/underflow)
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int MEM_LATENCY = 4,
    parameter int OUT_W       = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_busy,
    input  logic              i_read_req,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic              d_busy,
    input  logic              d_read_req,
    input  logic              d_wrt_mem,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_valid,
    output logic              i_grant,
    output logic              d_grant,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              i_data_valid,
    output logic              d_data_valid,
    output logic [DATA_W-1:0] mem_data,
    output logic              err
);

    arb_state_e state;
    owner_e     owner;
    owner_e     last;

    logic i_req, d_req;
    logic issue;
    logic zero_nxt, ovf, unf;

    assign i_req = i_busy;
    assign d_req = d_busy | d_wrt_mem;

    // Grants decode straight from the state flops, so they change only on
    // a clock edge; non-owner strobes are masked here and never reach memory.
    assign i_grant   = (state == ARB_GNT_I);
    assign d_grant   = (state == ARB_GNT_D);
    assign mem_en    = (i_grant && i_read_req) || (d_grant && (d_read_req || d_wrt_mem));
    assign mem_wr    = d_grant && d_wrt_mem;
    assign mem_addr  = i_grant ? i_mem_addr : (d_grant ? d_mem_addr : '0);
    assign mem_wdata = mem_wr ? d_wdata : '0;

    // A write takes priority over a same-cycle read strobe, so only a
    // pure read counts as outstanding.
    assign issue = (i_grant && i_read_req) || (d_grant && d_read_req && !d_wrt_mem);

    // Owner stays valid through DRAIN so in-flight words still get routed;
    // in IDLE any return is stray and goes nowhere.
    assign i_data_valid = mem_valid && (state != ARB_IDLE) && (owner == OWNER_I);
    assign d_data_valid = mem_valid && (state != ARB_IDLE) && (owner == OWNER_D);
    assign mem_data     = mem_rdata;

    mem_outstanding_ctr #(
        .OUT_W (OUT_W),
        .LIMIT (MEM_LATENCY + 1)
    ) u_ctr (
        .clk      (clk),
        .rst      (rst),
        .inc      (issue),
        .dec      (mem_valid),
        .zero_nxt (zero_nxt),
        .ovf      (ovf),
        .unf      (unf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
            owner <= OWNER_I;
            last  <= OWNER_I;
            err   <= 1'b0;
        end else begin
            err <= err | ovf | unf;
            case (state)
                ARB_IDLE: begin
                    if (d_wins(i_req, d_req, last)) begin
                        state <= ARB_GNT_D;
                        owner <= OWNER_D;
                        last  <= OWNER_D;
                    end else if (i_req) begin
                        state <= ARB_GNT_I;
                        owner <= OWNER_I;
                        last  <= OWNER_I;
                    end
                end
                // Leaving on zero_nxt lets a request drop coincide with the
                // last return and skip DRAIN entirely.
                ARB_GNT_I: if (!i_req) state <= zero_nxt ? ARB_IDLE : ARB_DRAIN;
                ARB_GNT_D: if (!d_req) state <= zero_nxt ? ARB_IDLE : ARB_DRAIN;
                ARB_DRAIN: if (zero_nxt) state <= ARB_IDLE;
                default:   state <= ARB_IDLE;
            endcase
        end
    end

endmodule
